clusterv_sram_initiator_bridge: RTL and testbench

Initiator-side bridge that converts a valid/ready request channel from a cluster master into accesses on the generic byte-enable SRAM port, and returns one response per request on a valid/ready response channel. It drives the initiator end of the same SRAM port that clusterv_main_sram_sky130_openram serves as target. It tracks the target's fixed one-cycle read latency and uses credit-based issue, so read data is never lost under response backpressure.

---
 rtl/clusterv_sram_pkg.sv | 22 ++
 rtl/clusterv_sram_rsp_fifo.sv | 65 ++++++
 rtl/clusterv_sram_initiator_bridge.sv | 115 +++++++++++
 tb/tb_clusterv_sram_initiator_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clusterv_sram_pkg.sv
// Shared response-entry layout and target timing for the cluster SRAM initiator bridge.
// Entry packing, LSB first: rdata, write flag, alignment-error flag.
package clusterv_sram_pkg;

    // Target returns read data one cycle after the address strobe; the bridge has one inflight stage to match.
    localparam int CLUSTERV_SRAM_RD_LATENCY = 1;

    localparam int RSP_RDATA_OFS = 0;

    function automatic int rsp_write_ofs(input int dw);
        return dw;
    endfunction

    function automatic int rsp_err_ofs(input int dw);
        return dw + 1;
    endfunction

    function automatic int rsp_entry_w(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/clusterv_sram_rsp_fifo.sv
// Synchronous response FIFO with registered head outputs and an occupancy count.
// Latency: push visible at the head the cycle after; push is dropped only if full without a pop.
module clusterv_sram_rsp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop_rdy,
    output logic                         pop_vld,
    output logic [WIDTH-1:0]             pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_rdy && (count_q != '0);
        do_push  = push_vld && ((count_q < CW'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_vld = (count_q != '0);
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/clusterv_sram_initiator_bridge.sv
// Valid/ready request channel to byte-enable SRAM initiator port, one in-order response per request.
// Latency: response at N+2; credit-based req_ready (queued + inflight - pop < RSP_DEPTH). Optional: CLUSTERV_SRAM_BRIDGE_ALIGN_CHECK_EN.
module clusterv_sram_initiator_bridge
    import clusterv_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_byte_en,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_write,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      i_read_en,
    output logic                      i_write_en,
    output logic [DATA_WIDTH/8-1:0]   i_byte_en,
    output logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic [DATA_WIDTH-1:0]     i_read_data
);
    localparam int EW   = rsp_entry_w(DATA_WIDTH);
    localparam int WOFS = rsp_write_ofs(DATA_WIDTH);
    localparam int EOFS = rsp_err_ofs(DATA_WIDTH);
    localparam int CW   = $clog2(RSP_DEPTH + 1);
    localparam int LW   = CW + 1;

    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] be_q, be_d;
    logic                    infl_vld_q, infl_vld_d;
    logic                    infl_wr_q, infl_wr_d;
    logic                    infl_err_q, infl_err_d;

    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_dat, push_dat;
    logic [LW-1:0] level;
    logic          pop, hs, err_now;

    always_comb begin
        pop       = rsp_valid & rsp_ready;
        level     = {1'b0, fifo_count} - LW'(pop) + LW'(infl_vld_q);
        // Held low in reset so no strobe can escape while the state is being cleared.
        req_ready = ~reset && (level < LW'(RSP_DEPTH));
        hs        = req_valid & req_ready;
`ifdef CLUSTERV_SRAM_BRIDGE_ALIGN_CHECK_EN
        err_now   = (req_addr[1:0] != 2'b00);
`else
        err_now   = 1'b0;
`endif
        i_write_en = hs & req_write & ~err_now;
        i_read_en  = hs & ~req_write & ~err_now;
        addr_d     = hs ? req_addr    : addr_q;
        wdata_d    = hs ? req_wdata   : wdata_q;
        be_d       = hs ? req_byte_en : be_q;
        infl_vld_d = hs;
        infl_wr_d  = req_write;
        infl_err_d = err_now;

        // Read data is only meaningful in the cycle after the read strobe.
        push_dat = '0;
        push_dat[RSP_RDATA_OFS +: DATA_WIDTH] = (infl_wr_q | infl_err_q) ? '0 : i_read_data;
        push_dat[WOFS] = infl_wr_q;
        push_dat[EOFS] = infl_err_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            infl_vld_q <= 1'b0;
            infl_wr_q  <= 1'b0;
            infl_err_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            infl_vld_q <= infl_vld_d;
            infl_wr_q  <= infl_wr_d;
            infl_err_q <= infl_err_d;
        end
    end

    assign i_addr       = addr_d;
    assign i_write_data = wdata_d;
    assign i_byte_en    = be_d;

    clusterv_sram_rsp_fifo #(
        .WIDTH (EW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (infl_vld_q),
        .push_dat (push_dat),
        .pop_rdy  (rsp_ready),
        .pop_vld  (rsp_valid),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );

    assign rsp_rdata = fifo_dat[RSP_RDATA_OFS +: DATA_WIDTH];
    assign rsp_write = fifo_dat[WOFS];
    assign rsp_err   = fifo_dat[EOFS];

endmodule

// File: tb/tb_clusterv_sram_initiator_bridge.sv
// Scoreboard bench for the SRAM initiator bridge: random and directed requests against a word-array reference model.
// A behavioural one-cycle-latency SRAM target sits on the initiator port.
module tb_clusterv_sram_initiator_bridge;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_byte_en = '0;
    logic          rsp_valid, rsp_write, rsp_err;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] i_addr;
    logic          i_read_en, i_write_en;
    logic [3:0]    i_byte_en;
    logic [DW-1:0] i_write_data;
    logic [DW-1:0] i_read_data = '0;

    clusterv_sram_initiator_bridge #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (DEPTH)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_byte_en  (req_byte_en),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_write    (rsp_write),
        .rsp_err      (rsp_err),
        .i_addr       (i_addr),
        .i_read_en    (i_read_en),
        .i_write_en   (i_write_en),
        .i_byte_en    (i_byte_en),
        .i_write_data (i_write_data),
        .i_read_data  (i_read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        wr;
        logic        err;
        int          issue_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        exp_q[$];
    int          compared = 0, mismatched = 0;
    int          cyc = 0, issued = 0, popped = 0;
    bit          lat_chk = 0;
    bit          prev_hold = 0;
    logic [33:0] prev_rsp;
    logic [31:0] tgt_mem [256];
    logic [31:0] ref_mem [256];

    always @(posedge clock) cyc++;

    // SRAM target: byte-enable write, registered read, addr[1:0] ignored.
    always @(posedge clock) begin
        logic [31:0] w;
        if (i_write_en) begin
            w = tgt_mem[i_addr[9:2]];
            for (int b = 0; b < 4; b++) if (i_byte_en[b]) w[8*b +: 8] = i_write_data[8*b +: 8];
            tgt_mem[i_addr[9:2]] <= w;
        end
        if (i_read_en) i_read_data <= tgt_mem[i_addr[9:2]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic bit misaligned(input logic [AW-1:0] a);
`ifdef CLUSTERV_SRAM_BRIDGE_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t ref_issue(input logic w, input logic [AW-1:0] a,
                                       input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        int   idx = int'(a) / 4;
        e.rdata = '0; e.wr = w; e.err = 1'b0; e.issue_cyc = 0; e.chk_lat = 0;
        if (misaligned(a)) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end else begin
            e.rdata = ref_mem[idx];
        end
        return e;
    endfunction

    logic pop_now, hs_m;
    exp_t e_m;

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            issued = 0;
            popped = 0;
            prev_hold = 0;
        end else begin
            pop_now = rsp_valid && rsp_ready;
            chk("req_ready", req_ready, (issued - popped - int'(pop_now)) < DEPTH);
            hs_m = req_valid && req_ready;
            chk("i_write_en", i_write_en, hs_m && req_write && !misaligned(req_addr));
            chk("i_read_en", i_read_en, hs_m && !req_write && !misaligned(req_addr));
            if (i_read_en || i_write_en) chk("i_addr", i_addr, req_addr);
            if (prev_hold) begin
                chk("hold_valid", rsp_valid, 1'b1);
                chk("hold_data", {rsp_rdata, rsp_write, rsp_err}, prev_rsp);
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_rsp  = {rsp_rdata, rsp_write, rsp_err};
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rsp: got response rdata %h with no outstanding request", rsp_rdata);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e_m.rdata);
                    chk("rsp_write", rsp_write, e_m.wr);
                    chk("rsp_err", rsp_err, e_m.err);
                    if (e_m.chk_lat) chk("latency", 64'(cyc - e_m.issue_cyc), 64'd2);
                end
                popped++;
            end
            if (hs_m) begin
                e_m = ref_issue(req_write, req_addr, req_wdata, req_byte_en);
                e_m.issue_cyc = cyc;
                e_m.chk_lat = lat_chk;
                exp_q.push_back(e_m);
                issued++;
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        int t = 0;
        bit done = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_byte_en = be;
        while (!done) begin
            @(negedge clock);
            if (req_ready) done = 1;
            else begin
                t++;
                if (t > 200) begin
                    compared++; mismatched++;
                    $display("FAIL send_timeout: req_ready stuck low for addr %h", a);
                    done = 1;
                end
            end
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((issued != popped || exp_q.size() != 0) && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 200) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: issued %0d popped %0d", issued, popped);
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, start;
        bit done_r;
        logic [1:0] lo;
        for (int i = 0; i < 256; i++) begin
            tgt_mem[i] = $urandom;
            ref_mem[i] = tgt_mem[i];
        end
        repeat (3) @(posedge clock);
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_write", rsp_write, 1'b0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_i_read_en", i_read_en, 1'b0);
        chk("reset_i_write_en", i_write_en, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Full write then read back.
        lat_chk = 1;
        send(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        send(1'b0, 10'h010, 32'h0, 4'h0);
        drain();

        // Partial byte-enable merge.
        send(1'b1, 10'h014, 32'hFFFFFFFF, 4'hF);
        send(1'b1, 10'h014, 32'h11223344, 4'b0101);
        send(1'b0, 10'h014, 32'h0, 4'h0);
        drain();

        // Backpressure: credit stops acceptance after RSP_DEPTH requests.
        lat_chk = 0;
        rsp_ready = 1'b0;
        base = issued;
        fork
            begin
                send(1'b0, 10'h010, 32'h0, 4'h0);
                send(1'b0, 10'h014, 32'h0, 4'h0);
                send(1'b0, 10'h000, 32'h0, 4'h0);
                send(1'b0, 10'h004, 32'h0, 4'h0);
            end
            begin
                repeat (6) @(posedge clock);
                #1;
                chk("accepts_while_blocked", 64'(issued - base), 64'd2);
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Streaming throughput.
        lat_chk = 1;
        start = cyc;
        for (int i = 0; i < 8; i++) send(1'b0, 10'(i * 4), 32'h0, 4'h0);
        chk("stream_cycles", 64'(cyc - start), 64'd8);
        drain();
        lat_chk = 0;

        // Reset with responses queued and inflight.
        rsp_ready = 1'b0;
        send(1'b0, 10'h010, 32'h0, 4'h0);
        send(1'b0, 10'h014, 32'h0, 4'h0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h018;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_req_ready", req_ready, 1'b0);
        chk("reset_no_read_strobe", i_read_en, 1'b0);
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        lat_chk = 1;
        send(1'b0, 10'h010, 32'h0, 4'h0);
        drain();

`ifdef CLUSTERV_SRAM_BRIDGE_ALIGN_CHECK_EN
        send(1'b1, 10'h013, 32'hA5A5A5A5, 4'hF);
        send(1'b0, 10'h010, 32'h0, 4'h0);
        drain();
`endif
        lat_chk = 0;

        // Random traffic with random response backpressure.
        done_r = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clock); #1;
                    end
                    lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    send(1'($urandom_range(0, 1)), 10'(($urandom_range(0, 15) << 2) | lo),
                         $urandom, 4'($urandom_range(0, 15)));
                end
                done_r = 1;
            end
            begin
                while (!done_r) begin
                    @(posedge clock); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
